// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA timing generator. It keeps horizontal and vertical
//   counters that advance on pix_ce and issues pixel coordinates PIX_LAT
//   ticks ahead of the display. The sync and display-enable signals are
//   delayed by the same amount, so a pipelined picture source can answer
//   with pix_data that lines up with de.
//
//   Line and frame order: SYNC, BACK PORCH, ACTIVE, FRONT PORCH.
//
// Ports
//   vga_clk      in   pixel/system clock
//   sys_rst      in   synchronous reset, active-high, overrides pix_ce
//   pix_ce       in   pixel tick enable; all state advances only when 1
//   pix_data     in   colour for the coordinate issued PIX_LAT ticks earlier
//   pix_x/pix_y  out  requested pixel coordinate (0 outside the active area)
//   pix_req      out  pix_x/pix_y are inside the active area
//   frame_start  out  one-clock pulse after the tick that loads (0,0)
//   hsync/vsync  out  sync outputs, HS_POL/VS_POL level while in sync
//   de           out  display enable, aligned with rgb
//   rgb          out  pixel colour, 0 whenever de=0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 10,
    parameter int RGB_W    = 16,
    parameter int PIX_LAT  = 1
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    input  logic             pix_ce,
    input  logic [RGB_W-1:0] pix_data,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             pix_req,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // First active column/row, and the first one past the active area.
    localparam int H_ACT_BEG = H_SYNC + H_BP;
    localparam int H_ACT_END = H_ACT_BEG + H_ACTIVE;
    localparam int V_ACT_BEG = V_SYNC + V_BP;
    localparam int V_ACT_END = V_ACT_BEG + V_ACTIVE;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ORIG  = CNT_W'(H_ACT_BEG);
    localparam logic [CNT_W-1:0] V_ORIG  = CNT_W'(V_ACT_BEG);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // ---- stage 0: combinational decode of the counters ----
    logic h_act;
    logic v_act;
    logic hs_p0;
    logic vs_p0;
    logic de_p0;

    // Compare in int so a boundary equal to 2^CNT_W cannot alias to 0.
    assign h_act = (int'(h_cnt) >= H_ACT_BEG) && (int'(h_cnt) < H_ACT_END);
    assign v_act = (int'(v_cnt) >= V_ACT_BEG) && (int'(v_cnt) < V_ACT_END);
    assign hs_p0 = (int'(h_cnt) < H_SYNC);
    assign vs_p0 = (int'(v_cnt) < V_SYNC);
    assign de_p0 = h_act && v_act;

    assign pix_req = de_p0;
    assign pix_x   = de_p0 ? (h_cnt - H_ORIG) : '0;
    assign pix_y   = de_p0 ? (v_cnt - V_ORIG) : '0;

    // ---- stages 1..PIX_LAT: delay line matching the pix_data latency ----
    // The pipe holds "sync active" flags; polarity is applied at the output.
    logic hs_last;
    logic vs_last;
    logic de_last;

    if (PIX_LAT == 0) begin : g_no_pipe
        assign hs_last = hs_p0;
        assign vs_last = vs_p0;
        assign de_last = de_p0;
    end else begin : g_pipe
        logic [PIX_LAT-1:0] hs_p1;
        logic [PIX_LAT-1:0] vs_p1;
        logic [PIX_LAT-1:0] de_p1;

        always_ff @(posedge vga_clk) begin
            if (sys_rst) begin
                hs_p1 <= '0;
                vs_p1 <= '0;
                de_p1 <= '0;
            end else if (pix_ce) begin
                hs_p1 <= (hs_p1 << 1) | PIX_LAT'(hs_p0);
                vs_p1 <= (vs_p1 << 1) | PIX_LAT'(vs_p0);
                de_p1 <= (de_p1 << 1) | PIX_LAT'(de_p0);
            end
        end

        assign hs_last = hs_p1[PIX_LAT-1];
        assign vs_last = vs_p1[PIX_LAT-1];
        assign de_last = de_p1[PIX_LAT-1];
    end

    // ---- output stage: registered sync, de and colour ----
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            de    <= 1'b0;
            rgb   <= '0;
        end else if (pix_ce) begin
            hsync <= hs_last ? HS_POL : ~HS_POL;
            vsync <= vs_last ? VS_POL : ~VS_POL;
            de    <= de_last;
            rgb   <= de_last ? pix_data : '0;
        end
    end

    // The tick that wraps both counters is the one that loads (0,0); the
    // reset-loaded (0,0) never produces a pulse.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Drives a small timing configuration (15 x 8 ticks per frame, PIX_LAT=2,
//   active-low hsync, active-high vsync) through continuous running,
//   pix_ce toggling, random pix_ce, and mid-frame resets. A picture source
//   answers each coordinate with a tagged colour two ticks later. Expected
//   output words are queued per tick and popped when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int H_SYNC   = 2;
    localparam int H_BP     = 3;
    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 2;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam bit HS_POL   = 1'b0;
    localparam bit VS_POL   = 1'b1;
    localparam int CNT_W    = 5;
    localparam int RGB_W    = 16;
    localparam int PIX_LAT  = 2;

    localparam int HT    = H_SYNC + H_BP + H_ACTIVE + H_FP;  // 15
    localparam int VT    = V_SYNC + V_BP + V_ACTIVE + V_FP;  // 8
    localparam int FRAME = HT * VT;                          // 120
    localparam int HAB   = H_SYNC + H_BP;
    localparam int VAB   = V_SYNC + V_BP;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [15:0] rgb;
    } exp_t;

    logic             vga_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             pix_ce  = 1'b1;
    logic [RGB_W-1:0] pix_data;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic             pix_req;
    logic             frame_start;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [RGB_W-1:0] rgb;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CNT_W(CNT_W), .RGB_W(RGB_W),
        .PIX_LAT(PIX_LAT)
    ) dut (
        .vga_clk    (vga_clk),
        .sys_rst    (sys_rst),
        .pix_ce     (pix_ce),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_req    (pix_req),
        .frame_start(frame_start),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .rgb        (rgb)
    );

    function automatic logic [15:0] pix_fn(input logic [4:0] x, input logic [4:0] y);
        return {3'b101, y, 3'b010, x};
    endfunction

    // Picture source with PIX_LAT ticks of latency.
    logic [15:0] src_q [PIX_LAT];
    always @(posedge vga_clk) begin
        if (pix_ce) begin
            for (int i = PIX_LAT - 1; i > 0; i--) src_q[i] <= src_q[i-1];
            src_q[0] <= pix_fn(pix_x, pix_y);
        end
    end
    assign pix_data = src_q[PIX_LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state.
    int   mh;
    int   mv;
    exp_t pipe_q[$];
    exp_t exp_o;
    logic exp_fs;
    int   de_cnt;
    int   fs_cnt;
    logic count_en = 1'b0;

    function automatic exp_t idle_exp();
        exp_t e;
        e.hs  = !HS_POL;
        e.vs  = !VS_POL;
        e.de  = 1'b0;
        e.rgb = '0;
        return e;
    endfunction

    function automatic logic in_active(input int h, input int v);
        return (h >= HAB) && (h < HAB + H_ACTIVE) && (v >= VAB) && (v < VAB + V_ACTIVE);
    endfunction

    function automatic exp_t raw_exp(input int h, input int v);
        exp_t e;
        e.hs  = (h < H_SYNC) ? HS_POL : !HS_POL;
        e.vs  = (v < V_SYNC) ? VS_POL : !VS_POL;
        e.de  = in_active(h, v);
        e.rgb = e.de ? pix_fn(5'(h - HAB), 5'(v - VAB)) : 16'h0000;
        return e;
    endfunction

    task automatic model_reset();
        mh = 0;
        mv = 0;
        pipe_q.delete();
        for (int i = 0; i < PIX_LAT; i++) pipe_q.push_back(idle_exp());
        exp_o  = idle_exp();
        exp_fs = 1'b0;
    endtask

    // Called at a negative edge: check what the DUT shows now, drive the
    // next inputs, advance the model over the coming rising edge.
    task automatic step(input logic rst, input logic ce);
        logic act;
        act = in_active(mh, mv);
        check("hsync",       hsync,       exp_o.hs);
        check("vsync",       vsync,       exp_o.vs);
        check("de",          de,          exp_o.de);
        check("rgb",         rgb,         exp_o.rgb);
        check("frame_start", frame_start, exp_fs);
        check("pix_req",     pix_req,     act);
        check("pix_x",       pix_x,       act ? 32'(mh - HAB) : 32'd0);
        check("pix_y",       pix_y,       act ? 32'(mv - VAB) : 32'd0);
        if (count_en) begin
            if (de) de_cnt++;
            if (frame_start) fs_cnt++;
        end

        sys_rst = rst;
        pix_ce  = ce;
        if (rst) begin
            model_reset();
        end else if (ce) begin
            pipe_q.push_back(raw_exp(mh, mv));
            exp_o  = pipe_q.pop_front();
            exp_fs = (mh == HT - 1) && (mv == VT - 1);
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end else begin
            exp_fs = 1'b0;
        end
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    initial begin
        int ran;
        sys_rst = 1'b1;
        pix_ce  = 1'b1;
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk);
        model_reset();

        // Reset holds and overrides pix_ce.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Continuous running: one full-frame window for de and frame_start counts.
        repeat (10) step(1'b0, 1'b1);
        de_cnt   = 0;
        fs_cnt   = 0;
        count_en = 1'b1;
        repeat (FRAME) step(1'b0, 1'b1);
        count_en = 1'b0;
        check("de_per_frame", de_cnt, H_ACTIVE * V_ACTIVE);
        check("fs_per_frame", fs_cnt, 1);
        repeat (FRAME + 10) step(1'b0, 1'b1);

        // pix_ce 1,0,1,0: everything holds on the 0 cycles.
        for (int i = 0; i < 2 * FRAME + 20; i++) step(1'b0, (i % 2) == 0);

        // Irregular pix_ce.
        for (int i = 0; i < 300; i++) step(1'b0, 1'($urandom_range(0, 1)));

        // Mid-frame reset; next frame_start exactly one frame after release.
        repeat (47) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        ran = 0;
        while (frame_start !== 1'b1 && ran < 2 * FRAME) begin
            step(1'b0, 1'b1);
            ran++;
        end
        check("fs_after_rst", ran, FRAME);
        repeat (30) step(1'b0, 1'b1);

        // Reset while pix_ce is low, then idle, then resume.
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        repeat (FRAME + 15) step(1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
